// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles every non-clock signal of alu_arbiter into one bundle: the two
//   requester handshakes, the response bus and the shared-ALU connection.
//
//   slave  : the arbiter's side. It takes the requests and the ALU outputs, and
//            drives the acks, responses and ALU operands.
//   master : the side of the requesters and the ALU (mirror of slave).
//
//   Signals
//     req0/req1, op0/op1, a0/b0, a1/b1   requester handshake and operands
//     ack0/ack1                           one-cycle response strobes
//     rsp_result, rsp_flags, rsp_err      registered response
//     busy                                arbiter not idle
//     alu_a, alu_b, alu_opcode, alu_enable  operands and control to the ALU
//     alu_result, alu_flags               combinational ALU outputs
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic [5:0]        op0;
  logic [5:0]        op1;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;

  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;   // {zero, neg, carry, overflow}
  logic              rsp_err;
  logic              busy;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [5:0]        alu_opcode;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_flags,
    output ack0, ack1, rsp_result, rsp_flags, rsp_err, busy,
           alu_a, alu_b, alu_opcode, alu_enable
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_flags,
    input  ack0, ack1, rsp_result, rsp_flags, rsp_err, busy,
           alu_a, alu_b, alu_opcode, alu_enable
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Gives two requesters access to one shared combinational ALU. Only one
//   operation is in flight at a time. Each operation takes three cycles:
//   IDLE (the request is sampled), EXEC (the ALU is driven) and DONE (the
//   winner's ack pulses and the response is valid).
//
//   A divide or modulo by zero is trapped. The ALU is never enabled for it.
//   The response reads all-ones with zero flags, and rsp_err is high.
//
//   Ports
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    alu_arbiter_if.slave; see the interface header for its signals
//
//   Parameter
//     DATA_W operand/result width. Only 16 is supported, to match the ALU.
//
//   Configuration macro
//     ALU_ARB_FIXED_PRIO_EN  if defined, requester 0 always wins a tie and the
//                            round-robin pointer is not built. If undefined,
//                            ties go to the requester not served last.
// -----------------------------------------------------------------------------

// Opcode encodings. A project-wide alu_ops.v compiled ahead of this file
// takes precedence.
`ifndef ALU_ADD
  `define ALU_ADD 6'h00
`endif
`ifndef ALU_SUB
  `define ALU_SUB 6'h01
`endif
`ifndef ALU_DIV
  `define ALU_DIV 6'h06
`endif
`ifndef ALU_MOD
  `define ALU_MOD 6'h07
`endif

module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic              win_q;     // latched winner index
  logic              trap_q;    // latched divide/modulo-by-zero
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              last_q;    // requester served most recently
`endif

  // Candidate for the next operation, chosen from the live request inputs.
  // It is used only on the IDLE edge.
  logic              sel;
  logic [5:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_trap;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  //       path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_q;
`endif
    end else if (bus.req1) begin
      sel = 1'b1;
    end

    sel_op   = sel ? bus.op1 : bus.op0;
    sel_a    = sel ? bus.a1  : bus.a0;
    sel_b    = sel ? bus.b1  : bus.b0;
    sel_trap = ((sel_op == `ALU_DIV) || (sel_op == `ALU_MOD)) &&
               (sel_b == '0);
  end

  // The state, the latched operation and every output are registered in this
  // one block. The ALU operand outputs act as the latch for the operation, so
  // they keep the last latched values through DONE and IDLE.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  //       then updates from values sampled before the edge.
  // NOTE: all state is small control/data registers, so every register has an
  //       asynchronous reset and an abort leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      win_q          <= 1'b0;
      trap_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q         <= 1'b1;       // requester 0 wins the first tie
`endif
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      bus.alu_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            state          <= S_EXEC;
            win_q          <= sel;
            trap_q         <= sel_trap;
            bus.alu_a      <= sel_a;
            bus.alu_b      <= sel_b;
            bus.alu_opcode <= sel_op;
            bus.alu_enable <= ~sel_trap;  // a trapped op never reaches the ALU
            bus.busy       <= 1'b1;
          end
        end

        S_EXEC: begin
          state          <= S_DONE;
          bus.alu_enable <= 1'b0;
          if (trap_q) begin
            bus.rsp_result <= {DATA_W{1'b1}};
            bus.rsp_flags  <= 4'b0000;
            bus.rsp_err    <= 1'b1;
          end else begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_flags  <= bus.alu_flags;
            bus.rsp_err    <= 1'b0;
          end
          bus.ack0 <= ~win_q;
          bus.ack1 <=  win_q;
        end

        S_DONE: begin
          state    <= S_IDLE;
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_q   <= win_q;
`endif
        end

        default: begin
          state          <= S_IDLE;
          bus.ack0       <= 1'b0;
          bus.ack1       <= 1'b0;
          bus.busy       <= 1'b0;
          bus.alu_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
